fifo_sram_reader: RTL

- Read-side drain engine for the team's synchronous SRAM-backed FIFO.
- The FIFO's read data is valid one cycle after its read enable; this block converts that into a valid/ready streaming master port.
- Sustains one word per cycle when the consumer is ready and never reads an empty FIFO, so it is safe with FIFOs built without underrun protection.
- Sits between any SRAM FIFO instance and a downstream valid/ready consumer.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_skid_buf.sv | 68 ++++++
 rtl/fifo_sram_reader.sv | 67 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing for the SRAM FIFO read-side drain engine.
//               FIFO_SRAM_READER_REG_READY_EN selects the deeper, registered-ready skid.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

`ifdef FIFO_SRAM_READER_REG_READY_EN
    localparam int SKID_DEPTH = 3;
`else
    localparam int SKID_DEPTH = 2;
`endif

    typedef logic [1:0] level_t;

endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_skid_buf
// Description : Small in-order register FIFO, head always visible, zero read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output level_t                level_o
);

    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] w_shift [SKID_DEPTH];
    level_t                r_level;
    level_t                w_wr_idx;
    logic                  w_push;

    assign w_push   = push_i & ~flush_i;
    // A simultaneous pop shifts the queue down, so the new word lands one slot lower.
    assign w_wr_idx = r_level - level_t'(pop_i);

    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_shift
        if (gi == SKID_DEPTH - 1) begin : g_tail
            assign w_shift[gi] = '0;
        end else begin : g_body
            assign w_shift[gi] = r_mem[gi+1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                if (w_push && (w_wr_idx == level_t'(i))) begin
                    r_mem[i] <= push_data_i;
                end else if (pop_i) begin
                    r_mem[i] <= w_shift[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_level <= '0;
        end else begin
            r_level <= r_level + level_t'(w_push) - level_t'(pop_i);
        end
    end

    assign head_o  = r_mem[0];
    assign level_o = r_level;

endmodule
`default_nettype wire

// File: rtl/fifo_sram_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sram_reader
// Description : Drains a 1-cycle-latency SRAM FIFO into a valid/ready master port.
//               FIFO_SRAM_READER_REG_READY_EN removes the ready-to-read path.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sram_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  fifo_re_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  fifo_empty_i,
    input  logic                  flush_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic [1:0]            level_o
);

    logic       r_inflight;
    level_t     w_level;
    logic       w_pop;
    logic [2:0] w_occupancy;

    assign m_valid_o = (w_level != '0);
    assign w_pop     = m_valid_o & m_ready_i;

    // Occupancy counts buffered words plus the word the SRAM is returning.
`ifdef FIFO_SRAM_READER_REG_READY_EN
    assign w_occupancy = {1'b0, w_level} + {2'b00, r_inflight};
`else
    assign w_occupancy = {1'b0, w_level} + {2'b00, r_inflight} - {2'b00, w_pop};
`endif

    assign fifo_re_o = rst_ni & ~fifo_empty_i & ~flush_i &
                       (w_occupancy < 3'(SKID_DEPTH));

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_re_o;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (r_inflight),
        .push_data_i (fifo_rdata_i),
        .pop_i       (w_pop),
        .flush_i     (flush_i),
        .head_o      (m_data_o),
        .level_o     (w_level)
    );

    assign level_o = w_level;

endmodule
`default_nettype wire
